param_prio_scan_enco: RTL and testbench
=======================================

Name: param_prio_scan_enco

Overview:
- Parametrised, sequential successor to the team's 8-bit fixed-priority encoder.
- Captures a WIDTH-bit request vector and emits, one per cycle, the index of every set bit in priority order.
- Priority order is lowest-index-first by default, or highest-index-first by parameter.
- Sits between request sources (interrupt lines, pending-job masks) and a consumer that services one index per handshake.

Parameters:
- WIDTH, 8, number of request bits; legal range 2..256.
- MSB_FIRST, 0, priority order: 0 = bit 0 highest priority; 1 = bit WIDTH-1 highest priority.
- Derived localparam IDX_W = $clog2(WIDTH). It is not overridable.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  d_in holds a request vector.
- in_ready  output  1  block can accept a vector.
- d_in  input  WIDTH  request vector.
- out_valid  output  1  d_out/out_last/out_none valid.
- out_ready  input  1  consumer accepts current beat.
- d_out  output  IDX_W  index of current highest-priority pending bit.
- out_last  output  1  current beat is final beat for this vector.
- out_none  output  1  captured vector was all-zero; no index is being reported.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, pend=0.
  - Outputs: out_valid=0, d_out=0, out_last=0, out_none=0, in_ready=1.
  - Reset mid-scan discards all pending bits; no further beats are produced.
- Registers: state {IDLE, SCAN, EMPTY} and pend[WIDTH-1:0].
- Outputs are decoded from registered state/pend only. There is no combinational path from d_in/in_valid/out_ready to any output.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1: pend<=d_in.
  - Next state is SCAN if d_in!=0, else EMPTY.
  - in_valid=0: stay.
- SCAN:
  - in_ready=0, out_valid=1, out_none=0.
  - d_out = index of highest-priority set bit in pend: lowest set index if MSB_FIRST=0, highest set index if MSB_FIRST=1.
  - out_last=1 iff exactly one bit of pend is set.
  - On out_ready=1: clear bit d_out in pend. If out_last, go to IDLE; else stay in SCAN.
  - On out_ready=0: hold pend, d_out and out_last stable.
- EMPTY:
  - in_ready=0, out_valid=1, out_none=1, d_out=0, out_last=1.
  - On out_ready=1: go to IDLE; else hold.
- Latency:
  - First beat is valid the cycle after the input handshake.
  - k set bits produce exactly k beats; back-to-back beats are possible with out_ready held high.
  - in_ready returns high the cycle after the final beat's handshake. The fixed one-cycle bubble between vectors is intended.
- in_valid while in_ready=0 is ignored; d_in is not sampled.
- Encoding: d_out is an unsigned binary index, zero-extended to IDX_W.
- Bits of d_in above WIDTH do not exist; there is no truncation.
- The WIDTH=8, MSB_FIRST=0 first beat matches the legacy encoder's output for any nonzero input.
- All-zero input yields exactly one EMPTY beat (out_none=1). It never produces x.

Test Plan:
- Reset: assert rst asynchronously mid-SCAN with 3 bits pending -> out_valid=0, in_ready=1, d_out=0 immediately. After deassert there are no stray beats.
- WIDTH=8, MSB_FIRST=0, d_in=8'b1010_0110, out_ready=1 -> beats d_out=1,2,5,7 on consecutive cycles. out_last=1 only on 7; in_ready=1 the next cycle.
- Same vector, MSB_FIRST=1 -> beats 7,5,2,1, with out_last on 1.
- d_in=8'h00 -> single beat: out_valid=1, out_none=1, d_out=0, out_last=1; then IDLE.
- Backpressure: d_in=8'hFF, out_ready low for 3 cycles at the second beat -> d_out held at 1, out_last=0. in_valid pulses meanwhile are ignored. Total 8 beats 0..7.
- WIDTH=16, d_in=16'h8001 -> beats 0 then 15 (last). Repeat with rst asserted after beat 0 -> beat 15 never appears, out_valid=0.

Source files
------------

// File: rtl/param_prio_scan_enco.sv
// Sequential priority scanner: captures a request vector and emits the index of
// every set bit, one per handshake, in fixed priority order.
module param_prio_scan_enco #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b0,
   localparam int IDX_W    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] d_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] d_out,
   output logic             out_last,
   output logic             out_none,
   output logic [1:0]       dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; valid never depends combinationally on ready, and the payload
   // is held stable while valid is high and ready is low.

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_EMPTY = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic [IDX_W-1:0] sel_idx;
   logic             one_hot;

   // Later loop iterations win, so the scan direction sets the priority.
   always_comb begin
      sel_idx = '0;
      if (MSB_FIRST) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (pend_q[i]) sel_idx = IDX_W'(i);
         end
      end else begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pend_q[i]) sel_idx = IDX_W'(i);
         end
      end
   end

   assign one_hot = (pend_q != '0) && ((pend_q & (pend_q - WIDTH'(1))) == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               pend_d  = d_in;
               state_d = (d_in != '0) ? S_SCAN : S_EMPTY;
            end
         end
         S_SCAN: begin
            if (out_ready) begin
               pend_d[sel_idx] = 1'b0;
               if (one_hot) state_d = S_IDLE;
            end
         end
         S_EMPTY: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decode registered state only; no input reaches an output.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_none  = 1'b0;
      out_last  = 1'b0;
      d_out     = '0;
      case (state_q)
         S_IDLE: in_ready = 1'b1;
         S_SCAN: begin
            out_valid = 1'b1;
            d_out     = sel_idx;
            out_last  = one_hot;
         end
         S_EMPTY: begin
            out_valid = 1'b1;
            out_none  = 1'b1;
            out_last  = 1'b1;
         end
         default: in_ready = 1'b1;
      endcase
   end

   assign dbg_state = state_q;

endmodule

// File: tb/tb_param_prio_scan_enco.sv
// Directed bench for param_prio_scan_enco: LSB-first and MSB-first 8-bit
// instances plus a 16-bit instance, all sharing one clock and reset.
module tb_param_prio_scan_enco;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_out_none;
   logic [7:0] a_d_in;
   logic [2:0] a_d_out;
   logic [1:0] a_dbg;

   logic       m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_out_last, m_out_none;
   logic [7:0] m_d_in;
   logic [2:0] m_d_out;
   logic [1:0] m_dbg;

   logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last, c_out_none;
   logic [15:0] c_d_in;
   logic [3:0]  c_d_out;
   logic [1:0]  c_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   param_prio_scan_enco #(.WIDTH(8), .MSB_FIRST(1'b0)) u_a (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .d_in(a_d_in),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .d_out(a_d_out),
      .out_last(a_out_last), .out_none(a_out_none), .dbg_state(a_dbg));

   param_prio_scan_enco #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m (
      .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready), .d_in(m_d_in),
      .out_valid(m_out_valid), .out_ready(m_out_ready), .d_out(m_d_out),
      .out_last(m_out_last), .out_none(m_out_none), .dbg_state(m_dbg));

   param_prio_scan_enco #(.WIDTH(16), .MSB_FIRST(1'b0)) u_c (
      .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .d_in(c_d_in),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .d_out(c_d_out),
      .out_last(c_out_last), .out_none(c_out_none), .dbg_state(c_dbg));

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      int exp_lsb[4];
      int exp_msb[4];
      exp_lsb = '{1, 2, 5, 7};
      exp_msb = '{7, 5, 2, 1};

      a_in_valid = 0; a_d_in = '0; a_out_ready = 0;
      m_in_valid = 0; m_d_in = '0; m_out_ready = 0;
      c_in_valid = 0; c_d_in = '0; c_out_ready = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      chk("rst_in_ready", a_in_ready, 1);
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_d_out", a_d_out, 0);
      chk("rst_out_last", a_out_last, 0);
      chk("rst_out_none", a_out_none, 0);
      chk("rst_c_in_ready", c_in_ready, 1);

      // LSB-first scan of 1010_0110
      a_in_valid = 1; a_d_in = 8'b1010_0110;
      tick;
      a_in_valid = 0; a_out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         chk("lsb_valid", a_out_valid, 1);
         chk("lsb_d_out", a_d_out, exp_lsb[i]);
         chk("lsb_last", a_out_last, (i == 3) ? 1 : 0);
         chk("lsb_in_ready_busy", a_in_ready, 0);
         tick;
      end
      chk("lsb_done_in_ready", a_in_ready, 1);
      chk("lsb_done_valid", a_out_valid, 0);

      // MSB-first scan of the same vector
      m_in_valid = 1; m_d_in = 8'b1010_0110;
      tick;
      m_in_valid = 0; m_out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         chk("msb_valid", m_out_valid, 1);
         chk("msb_d_out", m_d_out, exp_msb[i]);
         chk("msb_last", m_out_last, (i == 3) ? 1 : 0);
         tick;
      end
      chk("msb_done_in_ready", m_in_ready, 1);
      chk("msb_done_valid", m_out_valid, 0);

      // All-zero vector gives a single EMPTY beat
      a_in_valid = 1; a_d_in = 8'h00;
      tick;
      a_in_valid = 0;
      chk("zero_valid", a_out_valid, 1);
      chk("zero_none", a_out_none, 1);
      chk("zero_d_out", a_d_out, 0);
      chk("zero_last", a_out_last, 1);
      tick;
      chk("zero_done_valid", a_out_valid, 0);
      chk("zero_done_in_ready", a_in_ready, 1);

      // Backpressure on 8'hFF with stray in_valid pulses
      a_in_valid = 1; a_d_in = 8'hFF;
      tick;
      a_in_valid = 0;
      chk("bp_beat0", a_d_out, 0);
      chk("bp_beat0_none", a_out_none, 0);
      tick;
      chk("bp_beat1", a_d_out, 1);
      a_out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         a_in_valid = ~a_in_valid; a_d_in = 8'h0F;
         tick;
         chk("bp_hold_d_out", a_d_out, 1);
         chk("bp_hold_last", a_out_last, 0);
         chk("bp_hold_valid", a_out_valid, 1);
         chk("bp_hold_in_ready", a_in_ready, 0);
      end
      a_in_valid = 0; a_out_ready = 1;
      for (int i = 1; i < 8; i++) begin
         chk("bp_d_out", a_d_out, i);
         chk("bp_last", a_out_last, (i == 7) ? 1 : 0);
         tick;
      end
      chk("bp_done_valid", a_out_valid, 0);
      tick;
      chk("bp_no_stray", a_out_valid, 0);

      // Asynchronous reset mid-scan with three bits pending
      a_in_valid = 1; a_d_in = 8'b0011_1000;
      tick;
      a_in_valid = 0; a_out_ready = 0;
      chk("rstmid_pre_valid", a_out_valid, 1);
      chk("rstmid_pre_d_out", a_d_out, 3);
      rst = 1'b1;
      #1;
      chk("rstmid_valid", a_out_valid, 0);
      chk("rstmid_in_ready", a_in_ready, 1);
      chk("rstmid_d_out", a_d_out, 0);
      #2 rst = 1'b0;
      a_out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("rstmid_no_stray", a_out_valid, 0);
      end

      // 16-bit: 16'h8001 gives beats 0 then 15
      c_in_valid = 1; c_d_in = 16'h8001;
      tick;
      c_in_valid = 0; c_out_ready = 1;
      chk("w16_beat0", c_d_out, 0);
      chk("w16_beat0_last", c_out_last, 0);
      tick;
      chk("w16_beat1", c_d_out, 15);
      chk("w16_beat1_last", c_out_last, 1);
      tick;
      chk("w16_done_valid", c_out_valid, 0);
      chk("w16_done_in_ready", c_in_ready, 1);

      // 16-bit again, reset after beat 0 so beat 15 never appears
      c_in_valid = 1; c_d_in = 16'h8001;
      tick;
      c_in_valid = 0;
      chk("w16r_beat0", c_d_out, 0);
      tick;
      rst = 1'b1;
      #1;
      chk("w16r_valid", c_out_valid, 0);
      chk("w16r_d_out", c_d_out, 0);
      #2 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("w16r_no_stray", c_out_valid, 0);
      end
      chk("w16r_in_ready", c_in_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
